// File: rtl/lfo_mod_unit_if.sv
// lfo_mod_unit_if: request/response bundle between channel slots and lfo_mod_unit
interface lfo_mod_unit_if #(
  parameter int FNUM_WIDTH = 10,
  parameter int CH_WIDTH   = 4,
  parameter int TREM_WIDTH = 5
);
  logic                  req_valid;
  logic [CH_WIDTH-1:0]   req_ch;
  logic [FNUM_WIDTH-1:0] fnum;
  logic                  dvb;
  logic                  dam;
  logic                  resp_valid;
  logic [CH_WIDTH-1:0]   resp_ch;
  logic [FNUM_WIDTH-1:0] vib_val;
  logic [TREM_WIDTH-1:0] trem_val;
  modport master (
    output req_valid, req_ch, fnum, dvb, dam,
    input  resp_valid, resp_ch, vib_val, trem_val
  );
  modport slave (
    input  req_valid, req_ch, fnum, dvb, dam,
    output resp_valid, resp_ch, vib_val, trem_val
  );
endinterface

// File: rtl/lfo_mod_unit.sv
// lfo_mod_unit: shared vibrato/tremolo LFO answering channel-tagged requests one cycle later
module lfo_mod_unit #(
  parameter int FNUM_WIDTH    = 10,
  parameter int VIB_IDX_WIDTH = 13,
  parameter int CH_WIDTH      = 4,
  parameter int TREM_WIDTH    = 5,
  parameter int TREM_MAX      = 26,
  parameter int TREM_DIV_LOG  = 6
) (
  input logic               clk,
  input logic               rst,
  input logic               sample_clk_en,
  input logic               lfo_hold,
  lfo_mod_unit_if.slave     bus
);
  localparam logic [TREM_WIDTH-1:0] TMAX = TREM_WIDTH'(TREM_MAX);
  logic [VIB_IDX_WIDTH-1:0] vib_idx_q, vib_idx_d;
  logic [TREM_WIDTH-1:0]    trem_level_q, trem_level_d;
  logic                     trem_up_q, trem_up_d;
  logic [TREM_DIV_LOG-1:0]  trem_div_q, trem_div_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [CH_WIDTH-1:0]      resp_ch_q, resp_ch_d;
  logic [FNUM_WIDTH-1:0]    vib_val_q, vib_val_d;
  logic [TREM_WIDTH-1:0]    trem_val_q, trem_val_d;
  logic [2:0]               oct;
  logic [FNUM_WIDTH-1:0]    d0, d1, d2;
  logic                     step, turn;
  always_comb begin
    oct          = vib_idx_q[VIB_IDX_WIDTH-1 -: 3];
    d0           = bus.fnum >> (FNUM_WIDTH-3);
    d1           = (oct[1:0] == 2'd3) ? d0 >> 1 : d0;
    d2           = bus.dvb ? d1 : d1 >> 1;
    step         = sample_clk_en && (&trem_div_q);
    turn         = trem_up_q ? (trem_level_q == TMAX) : (trem_level_q == '0);
    trem_up_d    = lfo_hold ? 1'b1 : (step && turn) ? ~trem_up_q : trem_up_q;
    trem_level_d = lfo_hold ? '0 : !step ? trem_level_q :
                   trem_up_d ? trem_level_q + TREM_WIDTH'(1) : trem_level_q - TREM_WIDTH'(1);
    trem_div_d   = lfo_hold ? '0 : trem_div_q + TREM_DIV_LOG'(sample_clk_en);
    vib_idx_d    = lfo_hold ? '0 : vib_idx_q + VIB_IDX_WIDTH'(sample_clk_en);
    resp_valid_d = bus.req_valid;
    resp_ch_d    = bus.req_valid ? bus.req_ch : resp_ch_q;
    vib_val_d    = bus.req_valid ? (oct[2] ? ~d2 : d2) : vib_val_q;
    trem_val_d   = bus.req_valid ? (bus.dam ? trem_level_q : trem_level_q >> 2) : trem_val_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vib_idx_q    <= '0;
      trem_level_q <= '0;
      trem_up_q    <= 1'b1;
      trem_div_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_ch_q    <= '0;
      vib_val_q    <= '0;
      trem_val_q   <= '0;
    end else begin
      vib_idx_q    <= vib_idx_d;
      trem_level_q <= trem_level_d;
      trem_up_q    <= trem_up_d;
      trem_div_q   <= trem_div_d;
      resp_valid_q <= resp_valid_d;
      resp_ch_q    <= resp_ch_d;
      vib_val_q    <= vib_val_d;
      trem_val_q   <= trem_val_d;
    end
  end
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ch    = resp_ch_q;
  assign bus.vib_val    = vib_val_q;
  assign bus.trem_val   = trem_val_q;
endmodule
